// File: rtl/onehot_mon_pkg.sv
// ============================================================================
// Module   : onehot_mon_pkg
// Brief    : Shared constants and FSM encoding for the one-hot ring monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package onehot_mon_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_LOCK_CNT  = 4;
  localparam int DEF_ERR_CNT_W = 8;
  localparam int IDX_W         = $clog2(DEF_WIDTH);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/onehot_encoder.sv
// ============================================================================
// Module   : onehot_encoder
// Brief    : Combinational one-hot to binary encoder with a legality flag
//            (exactly one bit set).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_encoder
  import onehot_mon_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int IDX_BITS = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]    i_a,
  output logic [IDX_BITS-1:0] o_idx,
  output logic                o_legal
);

  localparam int c_cnt_w = $clog2(WIDTH + 1);

  logic [c_cnt_w-1:0] w_cnt;

  // OR together the indices of all set bits and count them; the index is only
  // meaningful when the count is exactly one.
  always_comb begin
    o_idx = '0;
    w_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_a[i]) begin
        o_idx = o_idx | IDX_BITS'(i);
        w_cnt = w_cnt + c_cnt_w'(1);
      end
    end
    o_legal = (w_cnt == c_cnt_w'(1));
  end

endmodule

`default_nettype wire

// File: rtl/onehot_ring_monitor.sv
// ============================================================================
// Module   : onehot_ring_monitor
// Brief    : Receive-side checker for a rotating one-hot pattern. Two-stage
//            pipeline: stage 1 registers the sample, stage 2 encodes, checks
//            the rotation step, runs the HUNT/TRACK/LOCKED FSM and drives the
//            registered outputs. Optional direction detection is enabled by
//            defining ONEHOT_MON_DIR_DETECT_EN; otherwise only left rotation
//            is accepted and po_dir is tied low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_ring_monitor
  import onehot_mon_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int LOCK_CNT  = DEF_LOCK_CNT,
  parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pi_valid,
  input  logic [WIDTH-1:0]         pi_a,
  output logic [$clog2(WIDTH)-1:0] po_idx,
  output logic                     po_idx_valid,
  output logic                     po_locked,
  output logic                     po_err,
  output logic [ERR_CNT_W-1:0]     po_err_cnt,
  output logic                     po_dir
);

  localparam int                 c_idx_w    = $clog2(WIDTH);
  localparam logic [3:0]         c_lock_cnt = 4'(LOCK_CNT);
  localparam logic [c_idx_w-1:0] c_idx_max  = c_idx_w'(WIDTH - 1);

  state_t             r_state;
  logic               r_s1_valid;
  logic [WIDTH-1:0]   r_s1_a;
  logic [c_idx_w-1:0] r_prev;
  logic [3:0]         r_good;

  logic [c_idx_w-1:0] w_idx;
  logic [c_idx_w-1:0] w_nxt;
  logic               w_legal;
  logic               w_is_fwd;
  logic               w_good;
  logic               w_err;

`ifdef ONEHOT_MON_DIR_DETECT_EN
  logic [c_idx_w-1:0] w_prv;
  logic               w_is_bwd;
  logic               r_dir;
  logic               r_dir_known;

  assign po_dir = r_dir;
`else
  assign po_dir = 1'b0;
`endif

  onehot_encoder #(
    .WIDTH    (WIDTH),
    .IDX_BITS (c_idx_w)
  ) u_enc (
    .i_a     (r_s1_a),
    .o_idx   (w_idx),
    .o_legal (w_legal)
  );

  // Classify the stage-2 sample against the previous index (modulo WIDTH).
  always_comb begin
    w_nxt    = (r_prev == c_idx_max) ? '0 : r_prev + c_idx_w'(1);
    w_is_fwd = (w_idx == w_nxt);
`ifdef ONEHOT_MON_DIR_DETECT_EN
    w_prv    = (r_prev == '0) ? c_idx_max : r_prev - c_idx_w'(1);
    w_is_bwd = (w_idx == w_prv);
    // Before a direction is known either neighbour is acceptable; afterwards
    // only the neighbour in the detected direction is.
    w_good   = r_dir_known ? (r_dir ? w_is_bwd : w_is_fwd) : (w_is_fwd || w_is_bwd);
`else
    w_good   = w_is_fwd;
`endif
    w_err    = r_s1_valid && (!w_legal || ((r_state != HUNT) && !w_good));
  end

  // Sample pipeline, lock FSM, pulse outputs and saturating error counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid   <= 1'b0;
      r_s1_a       <= '0;
      r_state      <= HUNT;
      r_prev       <= '0;
      r_good       <= '0;
      po_idx       <= '0;
      po_idx_valid <= 1'b0;
      po_locked    <= 1'b0;
      po_err       <= 1'b0;
      po_err_cnt   <= '0;
`ifdef ONEHOT_MON_DIR_DETECT_EN
      r_dir        <= 1'b0;
      r_dir_known  <= 1'b0;
`endif
    end else begin
      r_s1_valid   <= pi_valid;
      r_s1_a       <= pi_a;
      po_idx_valid <= 1'b0;
      po_err       <= 1'b0;

      if (w_err) begin
        po_err <= 1'b1;
        if (po_err_cnt != '1) begin
          po_err_cnt <= po_err_cnt + ERR_CNT_W'(1);
        end
      end

      if (r_s1_valid) begin
        // Every legal sample re-anchors tracking, good step or not.
        if (w_legal) begin
          po_idx       <= w_idx;
          po_idx_valid <= 1'b1;
          r_prev       <= w_idx;
        end

        case (r_state)
          HUNT: begin
            if (w_legal) begin
              r_state <= TRACK;
              r_good  <= '0;
            end
          end
          TRACK: begin
            if (!w_legal) begin
              r_state <= HUNT;
              r_good  <= '0;
`ifdef ONEHOT_MON_DIR_DETECT_EN
              r_dir       <= 1'b0;
              r_dir_known <= 1'b0;
`endif
            end else if (w_good) begin
`ifdef ONEHOT_MON_DIR_DETECT_EN
              if (!r_dir_known) begin
                r_dir_known <= 1'b1;
                r_dir       <= !w_is_fwd;
              end
`endif
              r_good <= r_good + 4'd1;
              if ((r_good + 4'd1) == c_lock_cnt) begin
                r_state   <= LOCKED;
                po_locked <= 1'b1;
              end
            end else begin
              r_good <= '0;
            end
          end
          LOCKED: begin
            if (!w_legal) begin
              r_state   <= HUNT;
              r_good    <= '0;
              po_locked <= 1'b0;
`ifdef ONEHOT_MON_DIR_DETECT_EN
              r_dir       <= 1'b0;
              r_dir_known <= 1'b0;
`endif
            end else if (!w_good) begin
              r_state   <= TRACK;
              r_good    <= '0;
              po_locked <= 1'b0;
            end
          end
          default: begin
            r_state   <= HUNT;
            r_good    <= '0;
            po_locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
